// File: rtl/release_tag_sched.sv
// release_tag_sched
//
// Gathers physical register tags that are being freed and returns them to the
// free list. Tags arrive from two sources:
//   - retirement: up to two tags per cycle (ret_tag1 / ret_tag2)
//   - squash walk-back: one tag per cycle, valid/ready handshake (sq_tag)
// Both sources feed one circular FIFO. The FIFO drains to the free list's two
// release ports at up to two tags per cycle. comnum reports how many ports are
// valid. Draining pauses while fl_hold is high, for example during recovery.
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   ret_tag{1,2}[_val]         retire-released tags; ret_ready when 2 slots free
//   sq_tag, sq_val, sq_ready   squash-released tag handshake
//   fl_hold                    free list busy; suppress drain
//   released_tag{1,2}[_val]    registered tags to the free list
//   comnum                     number of valid release ports this cycle (0..2)
//   occupancy                  current FIFO entry count
//   overflow_err               sticky; a retire push was dropped on a full FIFO
module release_tag_sched #(
   parameter int unsigned PHY_REG_SEL = 6,
   parameter int unsigned DEPTH       = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [PHY_REG_SEL-1:0]   ret_tag1,
   input  logic                     ret_tag1_val,
   input  logic [PHY_REG_SEL-1:0]   ret_tag2,
   input  logic                     ret_tag2_val,
   output logic                     ret_ready,
   input  logic [PHY_REG_SEL-1:0]   sq_tag,
   input  logic                     sq_val,
   output logic                     sq_ready,
   input  logic                     fl_hold,
   output logic [PHY_REG_SEL-1:0]   released_tag1,
   output logic                     released_tag1_val,
   output logic [PHY_REG_SEL-1:0]   released_tag2,
   output logic                     released_tag2_val,
   output logic [1:0]               comnum,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   // FIFO storage and pointers
   logic [PHY_REG_SEL-1:0] mem_q [DEPTH];
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_nx, slot_t2, slot_sq;
   logic [CW-1:0]          count_q, count_d, free_slots;

   // Per-cycle push/pop bookkeeping
   logic [1:0]             rn, rn_acc, push_n, pn;
   logic                   ret_push;
   logic                   overflow_q, overflow_d;

   // Registered release outputs
   logic [PHY_REG_SEL-1:0] tag1_q, tag1_d, tag2_q, tag2_d;
   logic                   val1_q, val1_d, val2_q, val2_d;
   logic [1:0]             comnum_q, comnum_d;

   // Push side: admission decisions use the count at the start of the cycle.
   // Slots freed by a pop at the same edge are not offered to pushes.
   always_comb begin
      rn         = {1'b0, ret_tag1_val} + {1'b0, ret_tag2_val};
      free_slots = DepthC - count_q;
      ret_ready  = (free_slots >= CW'(2));
      rn_acc     = ret_ready ? rn : 2'd0;
      ret_push   = ret_ready && (rn != 2'd0);
      // Retire has priority on the write ports. The squash tag fits only
      // when fewer than two retire tags are being written and a slot is
      // left after them.
      sq_ready   = sq_val && (rn_acc < 2'd2) &&
                   (free_slots >= (CW'(rn_acc) + CW'(1)));
      push_n     = rn_acc + {1'b0, sq_ready};
      // A lone ret_tag2 takes the first free slot.
      slot_t2    = wr_ptr_q + AW'(ret_tag1_val);
      slot_sq    = wr_ptr_q + AW'(rn_acc);
      wr_ptr_d   = wr_ptr_q + AW'(push_n);
      overflow_d = overflow_q | ((rn != 2'd0) & ~ret_ready);
   end

   // Pop side: only entries present before the edge can drain, so a tag
   // needs at least one cycle to pass through the FIFO.
   always_comb begin
      if (fl_hold) begin
         pn = 2'd0;
      end else if (count_q >= CW'(2)) begin
         pn = 2'd2;
      end else begin
         pn = count_q[1:0];
      end
      rd_ptr_nx = rd_ptr_q + AW'(1);
      rd_ptr_d  = rd_ptr_q + AW'(pn);
      count_d   = count_q + CW'(push_n) - CW'(pn);
   end

   // Release port next state. A port that is not used keeps its tag.
   always_comb begin
      val1_d   = (pn != 2'd0);
      val2_d   = (pn == 2'd2);
      comnum_d = pn;
      tag1_d   = val1_d ? mem_q[rd_ptr_q]  : tag1_q;
      tag2_d   = val2_d ? mem_q[rd_ptr_nx] : tag2_q;
   end

   // Storage has no reset. Entries are only read after they have been written.
   always_ff @(posedge clk) begin
      if (ret_ready && ret_tag1_val) begin
         mem_q[wr_ptr_q] <= ret_tag1;
      end
      if (ret_ready && ret_tag2_val) begin
         mem_q[slot_t2] <= ret_tag2;
      end
      if (sq_ready) begin
         mem_q[slot_sq] <= sq_tag;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         tag1_q     <= '0;
         tag2_q     <= '0;
         val1_q     <= 1'b0;
         val2_q     <= 1'b0;
         comnum_q   <= 2'd0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag2_d;
         val1_q     <= val1_d;
         val2_q     <= val2_d;
         comnum_q   <= comnum_d;
      end
   end

   assign released_tag1     = tag1_q;
   assign released_tag1_val = val1_q;
   assign released_tag2     = tag2_q;
   assign released_tag2_val = val2_q;
   assign comnum            = comnum_q;
   assign occupancy         = count_q;
   assign overflow_err      = overflow_q;

endmodule

// File: tb/tb_release_tag_sched.sv
module tb_release_tag_sched;

   localparam int W = 6;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] ret_tag1, ret_tag2, sq_tag;
   logic         ret_tag1_val, ret_tag2_val, sq_val, fl_hold;
   logic         ret_ready, sq_ready;
   logic [W-1:0] released_tag1, released_tag2;
   logic         released_tag1_val, released_tag2_val;
   logic [1:0]   comnum;
   logic [3:0]   occupancy;
   logic         overflow_err;

   release_tag_sched #(.PHY_REG_SEL(W), .DEPTH(D)) dut (
      .clk               (clk),
      .reset             (reset),
      .ret_tag1          (ret_tag1),
      .ret_tag1_val      (ret_tag1_val),
      .ret_tag2          (ret_tag2),
      .ret_tag2_val      (ret_tag2_val),
      .ret_ready         (ret_ready),
      .sq_tag            (sq_tag),
      .sq_val            (sq_val),
      .sq_ready          (sq_ready),
      .fl_hold           (fl_hold),
      .released_tag1     (released_tag1),
      .released_tag1_val (released_tag1_val),
      .released_tag2     (released_tag2),
      .released_tag2_val (released_tag2_val),
      .comnum            (comnum),
      .occupancy         (occupancy),
      .overflow_err      (overflow_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: a queue of tags and the expected release port values
   int q[$];
   bit m_ovf, m_v1, m_v2, m_sr;
   int m_t1, m_t2, m_com;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 0; m_v1 = 0; m_v2 = 0; m_t1 = 0; m_t2 = 0; m_com = 0; m_sr = 0;
   endtask

   task automatic idle_inputs();
      ret_tag1_val = 0; ret_tag2_val = 0; sq_val = 0; fl_hold = 0;
      ret_tag1 = 0; ret_tag2 = 0; sq_tag = 0;
   endtask

   // Checks the combinational ready outputs against the model's free space.
   task automatic check_ready();
      int free, rn, racc;
      bit rr;
      free = D - q.size();
      rr   = (free >= 2);
      rn   = int'(ret_tag1_val) + int'(ret_tag2_val);
      racc = rr ? rn : 0;
      m_sr = sq_val && (racc < 2) && (free >= racc + 1);
      chk("ret_ready", ret_ready, rr);
      chk("sq_ready", sq_ready, m_sr);
   endtask

   // Advances the model by one clock edge: drain old entries first, then append
   // the accepted pushes in source order.
   task automatic model_step();
      int pn, rn;
      bit rr;
      rr = ((D - q.size()) >= 2);
      rn = int'(ret_tag1_val) + int'(ret_tag2_val);
      pn = fl_hold ? 0 : ((q.size() >= 2) ? 2 : q.size());
      m_v1 = (pn >= 1);
      m_v2 = (pn == 2);
      m_com = pn;
      if (pn >= 1) m_t1 = q.pop_front();
      if (pn == 2) m_t2 = q.pop_front();
      if (rr) begin
         if (ret_tag1_val) q.push_back(int'(ret_tag1));
         if (ret_tag2_val) q.push_back(int'(ret_tag2));
      end else if (rn > 0) begin
         m_ovf = 1;
      end
      if (m_sr) q.push_back(int'(sq_tag));
   endtask

   task automatic check_regs();
      chk("rel_val1", released_tag1_val, m_v1);
      chk("rel_val2", released_tag2_val, m_v2);
      chk("rel_tag1", released_tag1, m_t1);
      chk("rel_tag2", released_tag2, m_t2);
      chk("comnum", comnum, m_com);
      chk("occupancy", occupancy, q.size());
      chk("overflow_err", overflow_err, m_ovf);
   endtask

   // Runs one cycle with the inputs the caller has already set.
   task automatic cycle();
      #1;
      check_ready();
      model_step();
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic set_ret(input bit v1, input int t1, input bit v2, input int t2);
      ret_tag1_val = v1; ret_tag1 = W'(t1);
      ret_tag2_val = v2; ret_tag2 = W'(t2);
   endtask

   initial begin
      idle_inputs();
      model_reset();
      reset = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1;
      #1;
      check_regs();
      check_ready();
      chk("lit_reset_occ", occupancy, 0);
      chk("lit_reset_ret_ready", ret_ready, 1);
      chk("lit_reset_sq_ready", sq_ready, 0);

      // A retire pair drains on the next edge and then goes idle.
      set_ret(1, 5, 1, 9);
      cycle();
      set_ret(0, 0, 0, 0);
      cycle();
      chk("lit_pair_tag1", released_tag1, 5);
      chk("lit_pair_tag2", released_tag2, 9);
      chk("lit_pair_comnum", comnum, 2);
      cycle();
      chk("lit_pair_idle_comnum", comnum, 0);
      chk("lit_pair_idle_val1", released_tag1_val, 0);

      // A lone ret_tag2 is queued ahead of the squash tag.
      set_ret(0, 0, 1, 3);
      sq_val = 1; sq_tag = 12;
      #1;
      chk("lit_mix_sq_ready", sq_ready, 1);
      cycle();
      set_ret(0, 0, 0, 0);
      sq_val = 0;
      cycle();
      chk("lit_mix_tag1", released_tag1, 3);
      chk("lit_mix_tag2", released_tag2, 12);
      chk("lit_mix_comnum", comnum, 2);

      // A full retire pair blocks the squash tag, which is held until accepted.
      set_ret(1, 20, 1, 21);
      sq_val = 1; sq_tag = 33;
      #1;
      chk("lit_blk_sq_ready", sq_ready, 0);
      cycle();
      set_ret(0, 0, 0, 0);
      #1;
      chk("lit_blk_sq_ready2", sq_ready, 1);
      cycle();
      sq_val = 0;
      chk("lit_blk_pair_tag1", released_tag1, 20);
      chk("lit_blk_pair_tag2", released_tag2, 21);
      cycle();
      chk("lit_blk_sq_tag", released_tag1, 33);
      chk("lit_blk_sq_comnum", comnum, 1);
      cycle();

      // The FIFO fills under hold, then a further retire push overflows.
      fl_hold = 1;
      for (int i = 0; i < 4; i++) begin
         set_ret(1, 40 + 2 * i, 1, 41 + 2 * i);
         cycle();
      end
      set_ret(1, 60, 0, 0);
      #1;
      chk("lit_full_ret_ready", ret_ready, 0);
      chk("lit_full_occ", occupancy, 8);
      cycle();
      chk("lit_ovf_set", overflow_err, 1);
      chk("lit_ovf_occ", occupancy, 8);
      chk("lit_hold_noval", released_tag1_val, 0);
      set_ret(0, 0, 0, 0);
      fl_hold = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("lit_drain_tag1", released_tag1, 40 + 2 * i);
         chk("lit_drain_tag2", released_tag2, 41 + 2 * i);
      end
      chk("lit_ovf_sticky", overflow_err, 1);
      cycle();

      // Asynchronous reset while five tags are queued and the ports are valid.
      fl_hold = 1;
      for (int i = 0; i < 3; i++) begin
         set_ret(1, 2 * i, 1, 2 * i + 1);
         cycle();
      end
      set_ret(1, 7, 0, 0);
      cycle();
      set_ret(0, 0, 0, 0);
      fl_hold = 0;
      cycle();
      chk("lit_pre_rst_occ", occupancy, 5);
      chk("lit_pre_rst_val", released_tag1_val, 1);
      #2 reset = 0;
      #1;
      model_reset();
      chk("lit_rst_val1", released_tag1_val, 0);
      chk("lit_rst_val2", released_tag2_val, 0);
      chk("lit_rst_comnum", comnum, 0);
      chk("lit_rst_ovf", overflow_err, 0);
      check_regs();
      @(posedge clk);
      #3 reset = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("lit_post_rst_comnum", comnum, 0);
      end

      // Randomized traffic. A squash request is held until it is accepted.
      for (int i = 0; i < 2000; i++) begin
         fl_hold = (i < 1000) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 0);
         set_ret($urandom_range(1), int'($urandom_range(63)),
                 $urandom_range(1), int'($urandom_range(63)));
         if (!sq_val && ($urandom_range(2) == 0)) begin
            sq_val = 1;
            sq_tag = W'($urandom_range(63));
         end
         cycle();
         if (m_sr) sq_val = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/release_tag_sched.md
Name: release_tag_sched

Overview:
- Schedules the return of physical register tags to the free list.
- Collects tags freed by retirement (up to 2/cycle) and by squash walk-back after misprediction (1/cycle, valid/ready) into one FIFO.
- Drains the FIFO to the free list's two release ports at up to 2 tags/cycle, with matching comnum.
- Stalls the drain while the free list is in recovery.

Parameters:
- PHY_REG_SEL, 6, physical tag width (`PHY_REG_SEL).
- DEPTH, 8, FIFO entries; power of 2, >= 4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- ret_tag1  in  PHY_REG_SEL  first retire-released tag.
- ret_tag1_val  in  1  ret_tag1 valid.
- ret_tag2  in  PHY_REG_SEL  second retire-released tag.
- ret_tag2_val  in  1  ret_tag2 valid.
- ret_ready  out  1  FIFO can take 2 retire tags this cycle.
- sq_tag  in  PHY_REG_SEL  squash-released tag.
- sq_val  in  1  sq_tag valid.
- sq_ready  out  1  squash push accepted this cycle.
- fl_hold  in  1  free list busy (prmiss); do not drain.
- released_tag1  out  PHY_REG_SEL  tag to free list, port 1.
- released_tag1_val  out  1  port 1 valid.
- released_tag2  out  PHY_REG_SEL  tag to free list, port 2.
- released_tag2_val  out  1  port 2 valid.
- comnum  out  2  count of valid release ports (0..2).
- occupancy  out  log2(DEPTH)+1  FIFO entry count.
- overflow_err  out  1  sticky: retire push dropped.

Behaviour:
- Storage and pointers:
  - Circular FIFO with rd_ptr, wr_ptr (log2(DEPTH) bits, wrap modulo DEPTH) and count (0..DEPTH).
  - occupancy = count.
- Reset (reset=0, async):
  - count, pointers, overflow_err = 0.
  - released_tag*_val = 0, comnum = 0, released_tag* = 0.
- Push count: rn = ret_tag1_val + ret_tag2_val.
- ret_ready = (DEPTH - count) >= 2.
  - Uses start-of-cycle count; same-cycle pops are not credited.
- Retire push, when ret_ready = 1:
  - Valid tags written in order tag1 then tag2 to consecutive slots.
  - If only ret_tag2_val is set, it takes the first slot.
- Retire push with rn > 0 and ret_ready = 0:
  - All retire tags that cycle are dropped; overflow_err set to 1.
  - overflow_err clears only on reset.
- Squash push:
  - sq_ready = sq_val && (rn_acc < 2) && ((DEPTH - count) >= rn_acc + 1).
  - rn_acc = rn if ret_ready, else 0.
  - Retire always wins the write ports.
  - When accepted, sq_tag goes to the slot after any retire tags.
  - Not accepted → sq_val source must hold tag and val.
- Drain, each posedge:
  - pn = fl_hold ? 0 : min(count, 2).
  - The pn oldest entries load into released_tag1, then released_tag2.
  - Each *_val = 1 for exactly one cycle; comnum = pn.
  - Unused port: val = 0; its tag holds its previous value.
  - pn counts only entries present before the edge; a tag pushed at edge N is driven at edge N+1 at the earliest (1-cycle latency).
- fl_hold = 1:
  - Outputs val = 0, comnum = 0, no pop.
  - Pushes still proceed; queued tags are never lost.
- Count update: count_next = count + accepted_pushes - pn.
  - Simultaneous push and pop at full or empty is legal.
  - count never exceeds DEPTH, never underflows.
- Ordering: strict FIFO across both sources.
- Async reset mid-operation:
  - Queued tags are discarded.
  - Outputs drop to 0 immediately, not on the next edge.

Test Plan:
- Reset, then release reset → all outputs 0, occupancy = 0, ret_ready = 1, sq_ready = 0.
- Edge N: ret_tag1 = 5, ret_tag2 = 9, both val → at edge N+1, released_tag1 = 5, released_tag2 = 9, both val = 1, comnum = 2; next cycle both val = 0, comnum = 0.
- Same cycle: ret_tag2_val only (tag 3) plus sq_val with tag 12 → sq_ready = 1; next edge outputs 3 then 12, comnum = 2.
- Same cycle: ret_tag1_val and ret_tag2_val plus sq_val → sq_ready = 0; sq held; squash tag drains one cycle after the retire pair.
- fl_hold = 1 for 4 cycles while pushing 2 tags/cycle from empty, DEPTH = 8 → occupancy = 8, ret_ready = 0, no vals.
  - Then push 1 more with ret_ready = 0 → overflow_err = 1, occupancy stays 8.
  - Release fl_hold → drains 2/cycle in original order over 4 cycles; overflow_err remains 1.
- Assert reset with occupancy = 5 and outputs valid → vals drop to 0 asynchronously; after release, occupancy = 0 and nothing drains.
